// File: rtl/multicycle_adder.sv
// Multicycle adder/subtractor: accepts WIDTH-bit operands, adds one STEP-bit
// chunk per clock (LSB chunk first) and presents sum/cout/ovf with a
// valid/ready handshake. Subtraction is performed as a + ~b + ~cin.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Guarded so an illegal STEP does not also trigger a divide-by-zero.
  localparam int N    = (STEP >= 1) ? WIDTH / STEP : 1;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  if (STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
    $error("multicycle_adder: STEP must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  op_a, op_b, acc, acc_next;
  logic              carry;
  logic [IDXW-1:0]   idx;
  logic              accept, last_chunk;
  int unsigned       base;
  logic [STEP-1:0]   chunk_a, chunk_b;
  logic [STEP:0]     chunk_res;
  logic              ovf_next;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_chunk = (idx == IDXW'(N - 1));

  // Chunk datapath: add the current chunk and merge it into the accumulator.
  // Carry into the MSB is recovered as a^b^s of the top bit, so ovf needs no
  // separate split of the final chunk.
  always_comb begin
    base      = STEP * int'(idx);
    chunk_a   = op_a[base +: STEP];
    chunk_b   = op_b[base +: STEP];
    chunk_res = {1'b0, chunk_a} + {1'b0, chunk_b} + {{STEP{1'b0}}, carry};
    acc_next  = acc;
    acc_next[base +: STEP] = chunk_res[STEP-1:0];
    ovf_next  = chunk_a[STEP-1] ^ chunk_b[STEP-1] ^ chunk_res[STEP-1] ^ chunk_res[STEP];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Operand capture, chunk iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= cin ^ sub;
      idx   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_next;
      carry <= chunk_res[STEP];
      idx   <= idx + 1'b1;
      if (last_chunk) begin
        sum  <= acc_next;
        cout <= chunk_res[STEP];
        ovf  <= ovf_next;
      end
    end
  end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter STEP, default 4: bits added per clock cycle; STEP >= 1 and WIDTH % STEP == 0, otherwise the block SHALL raise an elaboration-time error.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port in_valid  input  1  operand request valid.
REQ-006 Port in_ready  output  1  block can accept operands; SHALL be 1 exactly when the FSM is in IDLE.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry-in for add, or borrow-in for subtract.
REQ-010 Port sub  input  1  mode select: 0 = a+b+cin, 1 = a-b-cin.
REQ-011 Port out_valid  output  1  result valid.
REQ-012 Port out_ready  input  1  consumer accepts the result.
REQ-013 Port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 Port cout  output  1  raw carry out of the MSB.
REQ-015 Port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 Accept occurs on a rising edge where in_valid=1 and in_ready=1; at accept the block SHALL latch the operands and move IDLE->RUN.
- Latched values: a; b, or ~b when sub=1; carry = cin, or ~cin when sub=1; chunk index = 0.
REQ-018 In RUN, each edge SHALL add one STEP-bit chunk, LSB chunk first, propagating the carry register between chunks.
REQ-019 Let N = WIDTH/STEP; the edge that processes chunk N-1 SHALL load sum, cout and ovf and move RUN->DONE.
- out_valid SHALL therefore rise exactly N cycles after the accept edge.
REQ-020 ovf SHALL equal (carry into the MSB) XOR (carry out of the MSB) for the effective addition.
REQ-021 In sub mode, cout SHALL be 1 when no borrow occurred.
REQ-022 sum, cout and ovf SHALL change only on the RUN->DONE edge and SHALL otherwise hold their last result.
- Intermediate chunk results SHALL live in a separate accumulator.
REQ-023 In DONE, out_valid=1 and the outputs SHALL hold stable until out_ready=1 is sampled.
- That edge SHALL move DONE->IDLE: out_valid=0 and in_ready=1 in the next cycle.
REQ-024 in_valid, a, b, cin and sub SHALL be ignored while in RUN or DONE.
- Operands changing after accept SHALL NOT affect the result.
REQ-025 in_valid=1 in IDLE on the same edge that DONE->IDLE completes SHALL NOT be accepted.
- in_ready is 0 in DONE, so minimum issue interval is N+2 cycles.
REQ-026 STEP == WIDTH SHALL give N=1, i.e. a single RUN cycle.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock, force state=IDLE, clear operand, accumulator, carry and index registers, and set sum=0, cout=0, ovf=0, out_valid=0.
- in_ready SHALL be 1 while rst_n=0.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation with no partial result visible.
- The first accept after rst_n rises SHALL behave as after power-up.

Verification
REQ-029 Add, WIDTH=16, STEP=4: a=0x00FF, b=0x0001, cin=0, sub=0 -> out_valid 4 cycles after accept; sum=0x0100, cout=0, ovf=0.
REQ-030 Signed overflow and carry wrap:
- a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1.
- a=0xFFFF, b=0x0001, cin=1, add -> sum=0x0001, cout=1, ovf=0.
REQ-031 Subtract: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x0007, b=0x0005, cin=1, sub=1 -> sum=0x0001, cout=1.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b.
- Required: sum, cout and ovf stable, in_ready=0, no new accept.
- out_ready=1 -> IDLE next cycle.
REQ-033 Reset mid-RUN: assert rst_n=0 at chunk 2 -> same cycle sum=0, out_valid=0, in_ready=1; a new accept then yields a correct result after 4 cycles.
REQ-034 Exhaustive truth table: WIDTH=1, STEP=1, all 8 {a,b,cin} combinations, sub=0 -> each sum/cout matches the full-adder truth table, out_valid 1 cycle after accept.
